// File: rtl/capture_dump_sequencer.sv
// Capture dump sequencer: once a logic-analyzer capture completes, sends a two-byte
// sync header and then every buffer word, MSB byte first, over a byte-wide UART
// transmit port. Afterwards it re-arms the analyzer, or parks until reset.
module capture_dump_sequencer #(
  parameter int          DATA_WIDTH   = 128,
  parameter int          ADDR_BITS    = 9,
  parameter int          DEPTH        = 512,
  parameter int          READ_LATENCY = 1,
  parameter logic [15:0] SYNC_WORD    = 16'hA55A,
  parameter bit          AUTO_REARM   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  done,
  output logic [ADDR_BITS-1:0]  read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [7:0]            uart_txdata,
  output logic                  uart_txen,
  input  logic                  uart_txactive,
  output logic                  la_reset,
  output logic                  busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
  localparam logic [IDX_W-1:0]     LAST_BYTE = IDX_W'(BYTES - 1);
  localparam logic [1:0]           LAT_END   = 2'(READ_LATENCY);

  // Sequencer states
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HDR0      = 3'd1;
  localparam logic [2:0] S_HDR1      = 3'd2;
  localparam logic [2:0] S_FETCH     = 3'd3;
  localparam logic [2:0] S_SEND      = 3'd4;
  localparam logic [2:0] S_REARM     = 3'd5;
  localparam logic [2:0] S_DONE_HOLD = 3'd6;

  // Per-byte transmit handshake stages
  localparam logic [1:0] TX_ISSUE = 2'd0;  // waiting for an idle UART to strobe
  localparam logic [1:0] TX_PULSE = 2'd1;  // uart_txen is high this cycle
  localparam logic [1:0] TX_GUARD = 2'd2;  // UART may not have raised txactive yet
  localparam logic [1:0] TX_WAIT  = 2'd3;  // wait for the UART to finish shifting

  logic [2:0]            state;
  logic [1:0]            tx_stage;
  logic [1:0]            lat_cnt;
  logic [IDX_W-1:0]      byte_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  done_q;
  logic [7:0]            tx_byte;
  logic                  done_rise;
  logic                  in_tx;
  logic                  tx_done;
  logic                  abort;

  assign done_rise = done & ~done_q;
  assign in_tx     = (state == S_HDR0) || (state == S_HDR1) || (state == S_SEND);
  assign tx_done   = in_tx && (tx_stage == TX_WAIT) && !uart_txactive;
  // Losing done mid-dump means the capture is gone; REARM and DONE_HOLD are past that point.
  assign abort     = !done && ((state == S_HDR0) || (state == S_HDR1) ||
                               (state == S_FETCH) || (state == S_SEND));

  // Select the byte presented to the UART: header bytes, else the shift register MSB byte
  always_comb begin
    // NOTE: assign a default first so every path drives tx_byte and no latch is inferred.
    tx_byte = shreg[DATA_WIDTH-1 -: 8];
    if (state == S_HDR0)
      tx_byte = SYNC_WORD[15:8];
    else if (state == S_HDR1)
      tx_byte = SYNC_WORD[7:0];
  end

  // Previous done level; tracked through reset so a level held across release is no edge
  always_ff @(posedge clk) begin
    done_q <= done;
  end

  // Transmit handshake: one-cycle strobe, guard cycle, then wait for the UART to go idle
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_txen   <= 1'b0;
      uart_txdata <= 8'h00;
      tx_stage    <= TX_ISSUE;
    end else begin
      // NOTE: non-blocking assignments throughout sequential logic; this default makes
      // uart_txen a single-cycle strobe unless the ISSUE branch below overrides it.
      uart_txen <= 1'b0;
      if (abort || !in_tx) begin
        tx_stage <= TX_ISSUE;
      end else begin
        case (tx_stage)
          TX_ISSUE: begin
            if (!uart_txen && !uart_txactive) begin
              uart_txen   <= 1'b1;
              uart_txdata <= tx_byte;
              tx_stage    <= TX_PULSE;
            end
          end
          TX_PULSE: tx_stage <= TX_GUARD;
          TX_GUARD: tx_stage <= TX_WAIT;
          default:  if (!uart_txactive) tx_stage <= TX_ISSUE;
        endcase
      end
    end
  end

  // Dump sequencing: header, per-word fetch/latch, byte serialization, re-arm
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      read_addr <= '0;
      busy      <= 1'b0;
      la_reset  <= 1'b0;
      lat_cnt   <= 2'd0;
      byte_idx  <= '0;
      shreg     <= '0;
    end else begin
      la_reset <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        read_addr <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (done_rise) begin
              state     <= S_HDR0;
              read_addr <= '0;
              busy      <= 1'b1;
            end
          end
          S_HDR0: if (tx_done) state <= S_HDR1;
          S_HDR1: begin
            if (tx_done) begin
              state   <= S_FETCH;
              lat_cnt <= 2'd0;
            end
          end
          S_FETCH: begin
            // read_addr has been stable READ_LATENCY cycles, so read_data is valid now
            if (lat_cnt == LAT_END) begin
              shreg    <= read_data;
              byte_idx <= '0;
              state    <= S_SEND;
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end
          S_SEND: begin
            if (tx_done) begin
              shreg    <= shreg << 8;
              byte_idx <= byte_idx + 1'b1;
              if (byte_idx == LAST_BYTE) begin
                if (read_addr == LAST_ADDR) begin
                  state <= S_REARM;
                end else begin
                  read_addr <= read_addr + 1'b1;
                  lat_cnt   <= 2'd0;
                  state     <= S_FETCH;
                end
              end
            end
          end
          S_REARM: begin
            busy <= 1'b0;
            if (AUTO_REARM) begin
              la_reset  <= 1'b1;
              read_addr <= '0;
              state     <= S_IDLE;
            end else begin
              state <= S_DONE_HOLD;
            end
          end
          S_DONE_HOLD: state <= S_DONE_HOLD;
          default:     state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_dump_sequencer.sv
// Bench for capture_dump_sequencer: three instances (latency 1 / latency 3 / no auto
// re-arm), each with a UART stub and a buffer model; byte streams are compared with a
// reference built from the buffer contents.
module tb_capture_dump_sequencer;

  localparam int N      = 3;
  localparam int DW     = 32;
  localparam int AW     = 3;
  localparam int DEP    = 4;
  localparam int WB     = DW / 8;
  localparam int NBYTES = 2 + DEP * WB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_s  [N];
  logic          done_s [N];
  logic          hold_s [N];
  logic [AW-1:0] addr_s [N];
  logic [7:0]    txd_s  [N];
  logic          txen_s [N];
  logic          la_s   [N];
  logic          busy_s [N];

  logic [DW-1:0] mem  [N][DEP];
  logic [DW-1:0] pipe [N][3];

  int         stub_cnt  [N] = '{default: 0};
  logic [7:0] cap_mem   [N][256];
  int         cap_cnt   [N] = '{default: 0};
  int         la_hi     [N] = '{default: 0};
  int         la_rise   [N] = '{default: 0};
  int         viol      [N] = '{default: 0};
  int         hold_txen [N] = '{default: 0};
  int         addr_viol [N] = '{default: 0};
  logic       txen_prev [N] = '{default: 1'b0};
  logic       la_prev   [N] = '{default: 1'b0};

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int RL = (g == 1) ? 3 : 1;
    localparam bit AR = (g == 2) ? 1'b0 : 1'b1;
    capture_dump_sequencer #(
      .DATA_WIDTH(DW), .ADDR_BITS(AW), .DEPTH(DEP), .READ_LATENCY(RL),
      .SYNC_WORD(16'hA55A), .AUTO_REARM(AR)
    ) u_dut (
      .clk           (clk),
      .reset         (rst_s[g]),
      .done          (done_s[g]),
      .read_addr     (addr_s[g]),
      .read_data     (pipe[g][RL-1]),
      .uart_txdata   (txd_s[g]),
      .uart_txen     (txen_s[g]),
      .uart_txactive (hold_s[g] || (stub_cnt[g] != 0)),
      .la_reset      (la_s[g]),
      .busy          (busy_s[g])
    );
  end

  // Buffer model: read_data follows read_addr after a pipeline of registers
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      pipe[i][0] <= mem[i][addr_s[i][1:0]];
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end

  // UART stub and bus monitor, evaluated mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (addr_s[i] >= AW'(DEP)) addr_viol[i]++;
      if (la_s[i] === 1'b1) la_hi[i]++;
      if (la_s[i] === 1'b1 && la_prev[i] !== 1'b1) la_rise[i]++;
      la_prev[i] = la_s[i];
      if (txen_s[i] === 1'b1) begin
        if ((stub_cnt[i] != 0) || hold_s[i] || txen_prev[i]) viol[i]++;
        if (hold_s[i]) hold_txen[i]++;
        if (cap_cnt[i] < 256) cap_mem[i][cap_cnt[i]] = txd_s[i];
        cap_cnt[i]++;
        stub_cnt[i] = 10;
      end else if (stub_cnt[i] != 0) begin
        stub_cnt[i]--;
      end
      txen_prev[i] = (txen_s[i] === 1'b1);
    end
  end

  // Reference: byte j of a dump from instance i
  function automatic logic [7:0] exp_byte(input int i, input int j);
    int w;
    int b;
    logic [DW-1:0] word;
    if (j == 0) return 8'hA5;
    if (j == 1) return 8'h5A;
    w    = (j - 2) / WB;
    b    = (j - 2) % WB;
    word = mem[i][w];
    return 8'(word >> (8 * (WB - 1 - b)));
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic fill_random(input int i);
    for (int w = 0; w < DEP; w++) mem[i][w] = $urandom;
  endtask

  task automatic start_dump(input int i);
    done_s[i] = 1'b0;
    tick(2);
    done_s[i] = 1'b1;
  endtask

  task automatic wait_bytes(input int i, input int target, input string tag);
    int t = 0;
    while (cap_cnt[i] < target && t < 4000) begin
      tick(1);
      t++;
    end
    total++;
    if (cap_cnt[i] < target) begin
      bad++;
      $display("FAIL %s timeout: bytes=%0d need=%0d", tag, cap_cnt[i], target);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      rst_s[i]  = 1'b1;
      done_s[i] = 1'b0;
      hold_s[i] = 1'b0;
      fill_random(i);
    end
    tick(3);
    for (int i = 0; i < N; i++) begin
      total++;
      if ({addr_s[i], txd_s[i], txen_s[i], la_s[i], busy_s[i]} !== '0) begin
        bad++;
        $display("FAIL reset_outputs inst%0d got=%h exp=0", i,
                 {addr_s[i], txd_s[i], txen_s[i], la_s[i], busy_s[i]});
      end
    end
    for (int i = 0; i < N; i++) rst_s[i] = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    int base, lr0, lh0;
    for (int round = 0; round < 2; round++) begin
      for (int w = 0; w < DEP; w++) begin
        logic [7:0] wb;
        wb = 8'(w);
        mem[0][w] = (round == 0) ? {WB{wb}} : $urandom;
      end
      base = cap_cnt[0];
      lr0  = la_rise[0];
      lh0  = la_hi[0];
      start_dump(0);
      wait_bytes(0, base + NBYTES, "basic");
      tick(40);
      total++;
      if (cap_cnt[0] - base !== NBYTES) begin
        bad++;
        $display("FAIL basic_count round%0d got=%0d exp=%0d", round, cap_cnt[0] - base, NBYTES);
      end
      for (int j = 0; j < NBYTES; j++) begin
        total++;
        if (cap_mem[0][base + j] !== exp_byte(0, j)) begin
          bad++;
          $display("FAIL basic_byte%0d round%0d got=%h exp=%h", j, round, cap_mem[0][base + j], exp_byte(0, j));
        end
      end
      total++;
      if (la_rise[0] - lr0 !== 1 || la_hi[0] - lh0 !== 1) begin
        bad++;
        $display("FAIL basic_la_pulse round%0d rises=%0d high_cycles=%0d exp=1/1", round, la_rise[0] - lr0, la_hi[0] - lh0);
      end
      total++;
      if (busy_s[0] !== 1'b0 || addr_s[0] !== '0) begin
        bad++;
        $display("FAIL basic_idle round%0d busy=%b addr=%0d exp=0/0", round, busy_s[0], addr_s[0]);
      end
    end
    done_s[0] = 1'b0;
    tick(2);
  endtask

  task automatic test_latency3();
    int base, lr0;
    fill_random(1);
    base = cap_cnt[1];
    lr0  = la_rise[1];
    start_dump(1);
    wait_bytes(1, base + NBYTES, "lat3");
    tick(40);
    total++;
    if (cap_cnt[1] - base !== NBYTES) begin
      bad++;
      $display("FAIL lat3_count got=%0d exp=%0d", cap_cnt[1] - base, NBYTES);
    end
    for (int j = 0; j < NBYTES; j++) begin
      total++;
      if (cap_mem[1][base + j] !== exp_byte(1, j)) begin
        bad++;
        $display("FAIL lat3_byte%0d got=%h exp=%h", j, cap_mem[1][base + j], exp_byte(1, j));
      end
    end
    total++;
    if (la_rise[1] - lr0 !== 1) begin
      bad++;
      $display("FAIL lat3_la_pulse got=%0d exp=1", la_rise[1] - lr0);
    end
    done_s[1] = 1'b0;
    tick(2);
  endtask

  task automatic test_stall();
    int base, k, h0;
    fill_random(0);
    k    = $urandom_range(4, 14);
    base = cap_cnt[0];
    h0   = hold_txen[0];
    start_dump(0);
    wait_bytes(0, base + k, "stall_pre");
    hold_s[0] = 1'b1;
    tick(500);
    total++;
    if (hold_txen[0] - h0 !== 0 || cap_cnt[0] - base !== k) begin
      bad++;
      $display("FAIL stall_hold txen_in_hold=%0d bytes=%0d exp=0/%0d", hold_txen[0] - h0, cap_cnt[0] - base, k);
    end
    hold_s[0] = 1'b0;
    wait_bytes(0, base + NBYTES, "stall_post");
    tick(40);
    total++;
    if (cap_cnt[0] - base !== NBYTES) begin
      bad++;
      $display("FAIL stall_count got=%0d exp=%0d", cap_cnt[0] - base, NBYTES);
    end
    for (int j = 0; j < NBYTES; j++) begin
      total++;
      if (cap_mem[0][base + j] !== exp_byte(0, j)) begin
        bad++;
        $display("FAIL stall_byte%0d got=%h exp=%h", j, cap_mem[0][base + j], exp_byte(0, j));
      end
    end
    done_s[0] = 1'b0;
    tick(2);
  endtask

  task automatic test_abort();
    int base, k, lr0;
    fill_random(0);
    k    = $urandom_range(3, 12);
    base = cap_cnt[0];
    lr0  = la_rise[0];
    start_dump(0);
    wait_bytes(0, base + k, "abort_pre");
    done_s[0] = 1'b0;
    tick(100);
    total++;
    if (cap_cnt[0] - base !== k) begin
      bad++;
      $display("FAIL abort_bytes got=%0d exp=%0d", cap_cnt[0] - base, k);
    end
    total++;
    if (la_rise[0] !== lr0 || busy_s[0] !== 1'b0 || addr_s[0] !== '0) begin
      bad++;
      $display("FAIL abort_state la_pulses=%0d busy=%b addr=%0d exp=0/0/0", la_rise[0] - lr0, busy_s[0], addr_s[0]);
    end
    base = cap_cnt[0];
    done_s[0] = 1'b1;
    wait_bytes(0, base + NBYTES, "abort_restart");
    tick(40);
    for (int j = 0; j < NBYTES; j++) begin
      total++;
      if (cap_mem[0][base + j] !== exp_byte(0, j)) begin
        bad++;
        $display("FAIL abort_restart_byte%0d got=%h exp=%h", j, cap_mem[0][base + j], exp_byte(0, j));
      end
    end
    done_s[0] = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    int base, k, c0, lr0;
    fill_random(0);
    k    = $urandom_range(4, 14);
    base = cap_cnt[0];
    start_dump(0);
    wait_bytes(0, base + k, "rstmid_pre");
    rst_s[0] = 1'b1;
    tick(1);
    total++;
    if ({addr_s[0], txd_s[0], txen_s[0], la_s[0], busy_s[0]} !== '0) begin
      bad++;
      $display("FAIL rstmid_in_reset got=%h exp=0", {addr_s[0], txd_s[0], txen_s[0], la_s[0], busy_s[0]});
    end
    tick(1);
    rst_s[0] = 1'b0;
    tick(1);
    total++;
    if ({addr_s[0], txen_s[0], la_s[0], busy_s[0]} !== '0) begin
      bad++;
      $display("FAIL rstmid_release got=%h exp=0", {addr_s[0], txen_s[0], la_s[0], busy_s[0]});
    end
    c0  = cap_cnt[0];
    lr0 = la_rise[0];
    tick(100);
    total++;
    if (cap_cnt[0] !== c0 || busy_s[0] !== 1'b0 || la_rise[0] !== lr0) begin
      bad++;
      $display("FAIL rstmid_no_dump new_bytes=%0d busy=%b la_pulses=%0d exp=0/0/0", cap_cnt[0] - c0, busy_s[0], la_rise[0] - lr0);
    end
    base = cap_cnt[0];
    start_dump(0);
    wait_bytes(0, base + NBYTES, "rstmid_restart");
    tick(40);
    for (int j = 0; j < NBYTES; j++) begin
      total++;
      if (cap_mem[0][base + j] !== exp_byte(0, j)) begin
        bad++;
        $display("FAIL rstmid_byte%0d got=%h exp=%h", j, cap_mem[0][base + j], exp_byte(0, j));
      end
    end
    done_s[0] = 1'b0;
    tick(2);
  endtask

  task automatic test_no_rearm();
    int base, c0;
    fill_random(2);
    base = cap_cnt[2];
    start_dump(2);
    wait_bytes(2, base + NBYTES, "norearm");
    tick(40);
    total++;
    if (cap_cnt[2] - base !== NBYTES) begin
      bad++;
      $display("FAIL norearm_count got=%0d exp=%0d", cap_cnt[2] - base, NBYTES);
    end
    for (int j = 0; j < NBYTES; j++) begin
      total++;
      if (cap_mem[2][base + j] !== exp_byte(2, j)) begin
        bad++;
        $display("FAIL norearm_byte%0d got=%h exp=%h", j, cap_mem[2][base + j], exp_byte(2, j));
      end
    end
    total++;
    if (la_hi[2] !== 0 || busy_s[2] !== 1'b0) begin
      bad++;
      $display("FAIL norearm_state la_high_cycles=%0d busy=%b exp=0/0", la_hi[2], busy_s[2]);
    end
    c0 = cap_cnt[2];
    done_s[2] = 1'b0;
    tick(3);
    done_s[2] = 1'b1;
    tick(200);
    total++;
    if (cap_cnt[2] !== c0 || busy_s[2] !== 1'b0 || la_hi[2] !== 0) begin
      bad++;
      $display("FAIL norearm_ignore new_bytes=%0d busy=%b la_high_cycles=%0d exp=0/0/0", cap_cnt[2] - c0, busy_s[2], la_hi[2]);
    end
  endtask

  task automatic test_protocol();
    for (int i = 0; i < N; i++) begin
      total++;
      if (viol[i] !== 0 || addr_viol[i] !== 0) begin
        bad++;
        $display("FAIL protocol inst%0d txen_violations=%0d addr_out_of_range=%0d exp=0/0", i, viol[i], addr_viol[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency3();
    test_stall();
    test_abort();
    test_reset_mid();
    test_no_rearm();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
